// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch over imem req/ack, decode from a
// latched IR, execute, data access over dmem req/ack, write-back and PC update.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic [4:0]  rf_rd,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata2,
  output logic        alu_src,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        alu_branch,
  output logic [31:0] pc,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] res_q, res_d;
  logic [31:0] ld_q, ld_d;

  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_legal;
  logic [31:0] pc_plus4, pc_target, jalr_target, branch_pc, wb_pc;

  // Instruction fields come only from the latched IR so they hold steady
  // from DECODE through WB regardless of what the fetch port does.
  assign opcode = ir_q[6:0];
  assign rf_rd  = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rf_rs1 = ir_q[19:15];
  assign rf_rs2 = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_legal  = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE,
                                    OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};

  assign alu_src = opcode inside {OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_JALR};

  always_comb begin
    imm = 32'd0;
    case (opcode)
      OP_I, OP_LOAD, OP_JALR: imm = {{20{ir_q[31]}}, ir_q[31:20]};
      OP_STORE:               imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BRANCH:              imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                                     ir_q[30:25], ir_q[11:8], 1'b0};
      OP_LUI:                 imm = {ir_q[31:12], 12'd0};
      OP_JAL:                 imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                                     ir_q[20], ir_q[30:21], 1'b0};
      default:                imm = 32'd0;
    endcase
  end

  assign pc_plus4    = pc_q + 32'd4;
  assign pc_target   = pc_q + imm;
  assign jalr_target = res_q & ~32'd1;
  // alu_branch is consumed in EXEC, where the branch resolves.
  assign branch_pc   = alu_branch ? pc_target : pc_plus4;
  assign wb_pc       = is_jal  ? pc_target :
                       is_jalr ? jalr_target : pc_plus4;

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_addr  = res_q;
  assign dmem_wdata = rf_rdata2;
  assign trap       = (state_q == S_TRAP);
  assign rf_wdata   = is_load ? ld_q : ((is_jal || is_jalr) ? pc_plus4 : res_q);

  always_comb begin
    // NOTE: every output and next-state value is defaulted first so that no
    // branch of the case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    res_d    = res_q;
    ld_d     = ld_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Held low while reset is asserted so no fetch is advertised in reset.
        imem_req = rst;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = is_legal ? S_EXEC : S_TRAP;
      end

      S_EXEC: begin
        res_d = alu_result;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          if (branch_pc[1:0] != 2'b00) begin
            state_d = S_TRAP;
          end else begin
            pc_d    = branch_pc;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end else begin
            ld_d    = dmem_rdata;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        // A misaligned target aborts the instruction: no write, PC unchanged.
        if (wb_pc[1:0] != 2'b00) begin
          state_d = S_TRAP;
        end else begin
          rf_we   = (rf_rd != 5'd0);
          pc_d    = wb_pc;
          state_d = S_FETCH;
        end
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      res_q   <= 32'd0;
      ld_q    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed for this cycle, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
      ld_q    <= ld_d;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed scenarios followed by random
// instructions, each compared against an instruction-level reference model.
module tb_core_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic        rf_we;
  logic [31:0] rf_wdata, rf_rdata2;
  logic        alu_src;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm, alu_result, pc;
  logic        alu_branch, trap;

  core_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .rf_rdata2(rf_rdata2), .alu_src(alu_src), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .imm(imm), .alu_result(alu_result), .alu_branch(alu_branch),
    .pc(pc), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state and the observations of the most recent instruction.
  logic [31:0] mpc;
  logic        m_trapped;
  int          g_we_cnt, g_we_cyc;
  logic [4:0]  g_rd;
  logic [31:0] g_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal_op(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
  endfunction

  // Immediate value assembled from the format tables with shifts and masks.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [31:0] hi;
    hi = i[31] ? 32'hFFFF_FFFF : 32'h0;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        return (hi << 11) | 32'(i[30:20]);
      7'b0100011:
        return (hi << 11) | (32'(i[30:25]) << 5) | 32'(i[11:7]);
      7'b1100011:
        return (hi << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      7'b0110111:
        return i & 32'hFFFF_F000;
      7'b1101111:
        return (hi << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      default:
        return 32'h0;
    endcase
  endfunction

  // Called at a falling edge with the DUT in FETCH; returns at a falling edge
  // with the DUT back in FETCH or in TRAP.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] r, input logic b,
                           input logic [31:0] ld, input logic [31:0] rs2v,
                           input int iw_n, input int dw_n);
    logic [6:0]  op;
    logic [31:0] e_imm, nxt, e_wd, old_pc;
    logic        e_src, e_trap, e_we, e_mem, e_store;
    int          base, e_cyc, cyc, iw, dw, n_dm;
    logic        fetched, addr_bad, fields_bad, dm_bad, timed_out;

    op      = ins[6:0];
    e_imm   = ref_imm(ins);
    e_src   = op inside {7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111, 7'b1100111};
    old_pc  = mpc;
    e_trap  = 1'b0; e_we = 1'b0; e_wd = 32'h0; e_mem = 1'b0; e_store = 1'b0;
    nxt     = mpc + 32'd4;
    base    = 4;
    case (op)
      7'b1100011: begin nxt = b ? mpc + e_imm : mpc + 32'd4; base = 3; end
      7'b0000011: begin e_mem = 1'b1; e_we = 1'b1; e_wd = ld; base = 5; end
      7'b0100011: begin e_mem = 1'b1; e_store = 1'b1; base = 4; end
      7'b1101111: begin nxt = mpc + e_imm; e_we = 1'b1; e_wd = mpc + 32'd4; end
      7'b1100111: begin nxt = r & 32'hFFFF_FFFE; e_we = 1'b1; e_wd = mpc + 32'd4; end
      7'b0110011, 7'b0010011, 7'b0110111: begin e_we = 1'b1; e_wd = r; end
      default: begin e_trap = 1'b1; base = 2; end
    endcase
    if (!e_trap && nxt[1:0] != 2'b00) begin e_trap = 1'b1; e_we = 1'b0; end
    if (ins[11:7] == 5'd0) e_we = 1'b0;
    e_cyc = base + iw_n + (e_mem ? dw_n : 0);
    if (!e_trap) mpc = nxt;
    m_trapped = e_trap;

    alu_result = r; alu_branch = b; rf_rdata2 = rs2v;
    cyc = 0; iw = 0; dw = 0; n_dm = 0; g_we_cnt = 0; g_we_cyc = 0; g_rd = 5'd0; g_wd = 32'h0;
    fetched = 1'b0; addr_bad = 1'b0; fields_bad = 1'b0; dm_bad = 1'b0; timed_out = 1'b1;
    while (cyc < 60) begin
      if (fetched && (imem_req || trap)) begin timed_out = 1'b0; break; end
      cyc++;
      imem_ack = 1'b0; dmem_ack = 1'b0;
      imem_rdata = $urandom; dmem_rdata = $urandom;
      if (imem_req) begin
        if (imem_addr !== old_pc) addr_bad = 1'b1;
        if (iw == iw_n) begin imem_ack = 1'b1; imem_rdata = ins; fetched = 1'b1; end
        else iw++;
      end else begin
        imem_ack = 1'($urandom_range(0, 1));
      end
      if (dmem_req) begin
        n_dm++;
        if (dmem_addr !== r || dmem_we !== e_store || (e_store && dmem_wdata !== rs2v))
          dm_bad = 1'b1;
        if (dw == dw_n) begin dmem_ack = 1'b1; dmem_rdata = ld; end
        else dw++;
      end
      if (rf_we) begin g_we_cnt++; g_we_cyc = cyc; g_rd = rf_rd; g_wd = rf_wdata; end
      if (fetched && cyc > iw_n + 1) begin
        if (rf_rs1 !== ins[19:15] || rf_rs2 !== ins[24:20] || rf_rd !== ins[11:7] ||
            opcode !== ins[6:0] || funct3 !== ins[14:12] || funct7 !== ins[31:25] ||
            imm !== e_imm || alu_src !== e_src)
          fields_bad = 1'b1;
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;

    check("timeout", 32'(timed_out), 32'd0);
    check("fetch_addr", 32'(addr_bad), 32'd0);
    check("fields", 32'(fields_bad), 32'd0);
    check("cycles", 32'(cyc), 32'(e_cyc));
    check("trap", 32'(trap), 32'(e_trap));
    check("pc", pc, e_trap ? old_pc : nxt);
    check("rf_we_count", 32'(g_we_cnt), e_we ? 32'd1 : 32'd0);
    if (e_we) begin
      check("rf_rd", 32'(g_rd), 32'(ins[11:7]));
      check("rf_wdata", g_wd, e_wd);
      check("wb_cycle", 32'(g_we_cyc), 32'(e_cyc));
    end
    check("dmem_cycles", 32'(n_dm), e_mem ? 32'(dw_n + 1) : 32'd0);
    check("dmem_fields", 32'(dm_bad), 32'd0);
  endtask

  task automatic do_reset();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_pc", pc, RESET_PC);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_fetch_req", 32'(imem_req), 32'd1);
    mpc = RESET_PC;
    m_trapped = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, r;
    logic [6:0]  op;
    int          sel, cnt;
    logic        seen;

    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    rf_rdata2 = 32'h0; alu_result = 32'h0; alu_branch = 1'b0;
    mpc = RESET_PC; m_trapped = 1'b0;
    @(negedge clk);
    do_reset();

    // addi x1,x0,5 with zero-wait fetch
    run_instr(32'h0050_0093, 32'd5, 1'b0, 32'h0, 32'h0, 0, 0);
    check("t1_wdata", g_wd, 32'd5);
    check("t1_rd", 32'(g_rd), 32'd1);
    check("t1_we_cycle", 32'(g_we_cyc), 32'd4);
    check("t1_pc", pc, 32'd4);

    // fetch ack delayed three cycles
    run_instr(32'h0050_0093, 32'd5, 1'b0, 32'h0, 32'h0, 3, 0);
    check("t2_pc", pc, 32'd8);

    run_instr(32'h0010_0113, 32'd1, 1'b0, 32'h0, 32'h0, 0, 0);
    run_instr(32'h0010_0113, 32'd1, 1'b0, 32'h0, 32'h0, 1, 0);
    check("t3_pc_before", pc, 32'h10);

    // beq x0,x0,-8 taken at pc 0x10
    run_instr(32'hFE00_0CE3, 32'h0, 1'b1, 32'h0, 32'h0, 0, 0);
    check("t3_pc", pc, 32'h08);
    check("t3_imm", imm, 32'hFFFF_FFF8);
    check("t3_no_we", 32'(g_we_cnt), 32'd0);

    // lw x2,0(x1) with two data wait states
    run_instr(32'h0000_A103, 32'h200, 1'b0, 32'hDEAD_BEEF, 32'h0, 0, 2);
    check("t4_wdata", g_wd, 32'hDEAD_BEEF);
    check("t4_pc", pc, 32'h0C);

    // jalr x0,0(x1) to 0x102 is misaligned
    run_instr(32'h0000_8067, 32'h102, 1'b0, 32'h0, 32'h0, 0, 0);
    check("t6_trap", 32'(trap), 32'd1);
    check("t6_no_we", 32'(g_we_cnt), 32'd0);
    do_reset();

    // reset asserted while a load waits in MEM
    run_instr(32'h0010_0113, 32'd1, 1'b0, 32'h0, 32'h0, 0, 0);
    alu_result = 32'h300;
    imem_ack = 1'b1; imem_rdata = 32'h0000_A103;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (dmem_req) begin seen = 1'b1; break; end
    end
    check("t7_mem_reached", 32'(seen), 32'd1);
    rst = 1'b0;
    #1;
    check("t7_dmem_req_drop", 32'(dmem_req), 32'd0);
    check("t7_pc", pc, RESET_PC);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t7_refetch_req", 32'(imem_req), 32'd1);
    check("t7_refetch_addr", imem_addr, RESET_PC);
    mpc = RESET_PC;

    // illegal opcode 0x7F traps and stays trapped
    run_instr(32'h0000_007F, 32'h0, 1'b0, 32'h0, 32'h0, 0, 0);
    check("t5_trap", 32'(trap), 32'd1);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (imem_req) cnt++;
    end
    check("t5_no_fetch", 32'(cnt), 32'd0);
    check("t5_trap_sticky", 32'(trap), 32'd1);
    do_reset();

    // random instruction stream
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 11);
      ins = $urandom;
      case (sel)
        0, 10:   op = 7'b0110011;
        1, 9:    op = 7'b0010011;
        2:       op = 7'b0000011;
        3:       op = 7'b0100011;
        4, 5:    op = 7'b1100011;
        6:       op = 7'b1101111;
        7:       op = 7'b1100111;
        8:       op = 7'b0110111;
        default: begin
          do op = 7'($urandom); while (is_legal_op(op));
        end
      endcase
      ins[6:0] = op;
      if (op == 7'b1100011 && $urandom_range(0, 3) != 0) ins[8] = 1'b0;
      if (op == 7'b1101111 && $urandom_range(0, 3) != 0) ins[21] = 1'b0;
      r = $urandom;
      if (op == 7'b1100111 && $urandom_range(0, 3) != 0) r[1] = 1'b0;
      run_instr(ins, r, 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
      if (m_trapped) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
